// File: rtl/ff_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ff_reg_bank
//  Description : WIDTH-bit multi-mode register bank. Supports hold, parallel
//                load, per-bit JK, toggle mask, shift left/right with serial
//                in/out, and up/down counting. It has a clock enable, a
//                counter wrap pulse and a change-detect pulse. All outputs
//                are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module ff_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] t,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             wrap,
    output logic             changed
);

    localparam logic [2:0]       c_mode_hold   = 3'b000;
    localparam logic [2:0]       c_mode_load   = 3'b001;
    localparam logic [2:0]       c_mode_jk     = 3'b010;
    localparam logic [2:0]       c_mode_toggle = 3'b011;
    localparam logic [2:0]       c_mode_shl    = 3'b100;
    localparam logic [2:0]       c_mode_shr    = 3'b101;
    localparam logic [2:0]       c_mode_cntup  = 3'b110;
    localparam logic [2:0]       c_mode_cntdn  = 3'b111;
    localparam logic [WIDTH-1:0] c_one         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_zero        = {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_wrap;
    logic             r_changed;

    logic [WIDTH-1:0] w_q_next;
    logic             w_sout_next;
    logic             w_wrap_next;

    // Next-state decode for an enabled edge; sout holds outside the shift modes
    always_comb begin
        w_q_next    = r_q;
        w_sout_next = r_sout;
        w_wrap_next = 1'b0;
        case (mode)
            c_mode_hold:   w_q_next = r_q;
            c_mode_load:   w_q_next = d;
            // JK characteristic per bit: set where J and Q=0, keep where K=0 and Q=1
            c_mode_jk:     w_q_next = (j & ~r_q) | (~k & r_q);
            c_mode_toggle: w_q_next = r_q ^ t;
            c_mode_shl: begin
                w_q_next    = {r_q[WIDTH-2:0], sin};
                w_sout_next = r_q[WIDTH-1];
            end
            c_mode_shr: begin
                w_q_next    = {sin, r_q[WIDTH-1:1]};
                w_sout_next = r_q[0];
            end
            c_mode_cntup: begin
                w_q_next    = r_q + c_one;
                w_wrap_next = &r_q;
            end
            c_mode_cntdn: begin
                w_q_next    = r_q - c_one;
                w_wrap_next = (r_q == c_zero);
            end
            default: w_q_next = r_q;
        endcase
    end

    // State update: reset overrides everything, then enable gates the decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RESET_VAL;
            r_sout    <= 1'b0;
            r_wrap    <= 1'b0;
            r_changed <= 1'b0;
        end else if (en) begin
            r_q       <= w_q_next;
            r_sout    <= w_sout_next;
            r_wrap    <= w_wrap_next;
            r_changed <= (w_q_next != r_q);
        end else begin
            r_wrap    <= 1'b0;
            r_changed <= 1'b0;
        end
    end

    assign q       = r_q;
    assign sout    = r_sout;
    assign wrap    = r_wrap;
    assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_ff_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ff_reg_bank
//  Description : Directed self-checking bench for ff_reg_bank (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ff_reg_bank;

    localparam int WIDTH = 8;

    localparam logic [2:0] c_hold   = 3'b000;
    localparam logic [2:0] c_load   = 3'b001;
    localparam logic [2:0] c_jk     = 3'b010;
    localparam logic [2:0] c_toggle = 3'b011;
    localparam logic [2:0] c_shl    = 3'b100;
    localparam logic [2:0] c_shr    = 3'b101;
    localparam logic [2:0] c_cntup  = 3'b110;
    localparam logic [2:0] c_cntdn  = 3'b111;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] t;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             wrap;
    logic             changed;

    int checks   = 0;
    int failures = 0;

    ff_reg_bank #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .d       (d),
        .j       (j),
        .k       (k),
        .t       (t),
        .sin     (sin),
        .q       (q),
        .sout    (sout),
        .wrap    (wrap),
        .changed (changed)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq, input logic es,
                           input logic ew, input logic ec);
        chk({tag, ".q"},       32'(q),       32'(eq));
        chk({tag, ".sout"},    32'(sout),    32'(es));
        chk({tag, ".wrap"},    32'(wrap),    32'(ew));
        chk({tag, ".changed"}, 32'(changed), 32'(ec));
    endtask

    task automatic do_load(input logic [7:0] val);
        en = 1'b1; mode = c_load; d = val;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = c_load; d = 8'hFF;
        j = '0; k = '0; t = '0; sin = 1'b0;

        // Reset held for two edges while LOAD of 0xFF is presented
        tick(); tick();
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        rst = 1'b0; d = 8'hA5;
        tick();
        chk_all("load_a5", 8'hA5, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("load_a5_again", 8'hA5, 1'b0, 1'b0, 1'b0);

        // JK: F0 with j=3C k=66 -> hold/clr/inv/set/set/inv/clr/hold = 9C
        do_load(8'hF0);
        mode = c_jk; j = 8'h3C; k = 8'h66;
        tick();
        chk_all("jk_mix", 8'h9C, 1'b0, 1'b0, 1'b1);
        j = 8'h00; k = 8'h00;
        tick();
        chk_all("jk_hold", 8'h9C, 1'b0, 1'b0, 1'b0);
        j = 8'hFF; k = 8'hFF;
        tick();
        chk_all("jk_invert", 8'h63, 1'b0, 1'b0, 1'b1);

        // Toggle gated by enable
        do_load(8'h0F);
        en = 1'b0; mode = c_toggle; t = 8'hFF;
        tick();
        chk_all("toggle_en0", 8'h0F, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        tick();
        chk_all("toggle_en1", 8'hF0, 1'b0, 1'b0, 1'b1);

        // Shift chain
        do_load(8'h81);
        mode = c_shl; sin = 1'b0;
        tick();
        chk_all("shl", 8'h02, 1'b1, 1'b0, 1'b1);
        mode = c_shr; sin = 1'b1;
        tick();
        chk_all("shr", 8'h81, 1'b0, 1'b0, 1'b1);
        mode = c_hold;
        tick();
        chk_all("shift_hold", 8'h81, 1'b0, 1'b0, 1'b0);
        mode = c_shr; sin = 1'b0;
        tick();
        chk_all("shr2", 8'h40, 1'b1, 1'b0, 1'b1);
        do_load(8'h00);
        chk_all("sout_hold_load", 8'h00, 1'b1, 1'b0, 1'b1);

        // Counter wrap up then down
        do_load(8'hFE);
        mode = c_cntup;
        tick();
        chk_all("up_ff", 8'hFF, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("up_wrap", 8'h00, 1'b1, 1'b1, 1'b1);
        tick();
        chk_all("up_01", 8'h01, 1'b1, 1'b0, 1'b1);
        mode = c_cntdn;
        tick();
        chk_all("dn_00", 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("dn_wrap", 8'hFF, 1'b1, 1'b1, 1'b1);
        en = 1'b0;
        tick();
        chk_all("wrap_clear_en0", 8'hFF, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of counting
        do_load(8'h10);
        mode = c_cntup;
        tick();
        chk_all("mid_11", 8'h11, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("mid_12", 8'h12, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk_all("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_all("mid_01", 8'h01, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
